reu_dma_engine: RTL
===================

// Module: reu_dma_engine
// PURPOSE
//  DMA transfer engine of the REU: consumes Execute/XferType/CA/REUA/Length1 from the REU register
//  file and performs the byte-by-byte transfer between C64 memory and REU RAM.
//  Drives /DMA, C64 address/data/R-W and REU RAM strobes; returns NextCA, NextREUA, VerifyErr and
//  XferEnd to the register file, which owns all counters and status bits.
// PARAMETERS
//  RAM_AW      19  REU RAM address width (low bits of REUA used)
//  START_WAIT  1   PHI2 cycles /DMA held low before first byte cycle (CPU write-cycle drain), 1..3
// PORTS
//  PHI2       in   1       system clock; all state updates on negedge PHI2
//  Reset      in   1       reset, synchronous, active-high
//  Execute    in   1       start pulse from register file (sampled only in IDLE)
//  XferType   in   2       00 stash C64->REU, 01 fetch REU->C64, 10 swap, 11 verify
//  CA         in   16      current C64 address (register file)
//  REUA       in   RAM_AW  current REU address (register file)
//  Length1    in   1       current byte is the last one
//  BA         in   1       VIC bus available; low = stall
//  C64DIn     in   8       C64 data bus read value
//  RAMDIn     in   8       REU RAM read data
//  nDMA       out  1       active-low DMA request to expansion port
//  C64A       out  16      C64 address bus, = CA while bus owned
//  C64RnW     out  1       C64 R/W (1 = read)
//  C64DOE     out  1       drive C64 data bus
//  C64DOut    out  8       C64 write data
//  RAMA       out  RAM_AW  REU RAM address, = REUA
//  RAMnOE     out  1       RAM output enable, active low
//  RAMnWE     out  1       RAM write enable, active low
//  RAMDOut    out  8       RAM write data
//  NextCA     out  1       advance CA / decrement Length this cycle
//  NextREUA   out  1       advance REUA this cycle
//  VerifyErr  out  1       one-cycle pulse: verify mismatch
//  XferEnd    out  1       one-cycle pulse: transfer complete
//  Busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; nDMA=1, C64RnW=1, C64DOE=0, RAMnOE=1, RAMnWE=1, Next*/VerifyErr/XferEnd/Busy=0.
//  States: IDLE, START, STASH, FETCH, SWAP_RD, SWAP_WR, VERIFY, VERR, DONE.
//  IDLE: Execute=1 at negedge -> latch XferType, START. Execute in any other state ignored.
//  START: nDMA=0; after START_WAIT cycles -> per latched type STASH/FETCH/SWAP_RD/VERIFY.
//  nDMA=0 in every state except IDLE; C64A=CA, RAMA=REUA continuously.
//  Byte cycle (active state with BA=1): NextCA=NextREUA=1 combinationally for that PHI2 cycle,
//   register file increments at its closing negedge. BA=0: cycle stalled, no strobes, no Next*,
//   C64RnW=1, C64DOE=0, state held.
//  STASH: C64 read, RAMnWE=0, RAMDOut=C64DIn. FETCH: RAMnOE=0, C64RnW=0, C64DOE=1, C64DOut=RAMDIn.
//  SWAP_RD: C64 read + RAM read, latch both bytes at negedge, no Next*; -> SWAP_WR (2 cycles/byte).
//  SWAP_WR: C64 write latched RAM byte, RAM write latched C64 byte, Next* asserted.
//  VERIFY: C64 read + RAM read; compare at negedge. Mismatch -> VERR (takes priority over Length1).
//  VERR: VerifyErr=1 one cycle, no Next*, -> IDLE (no XferEnd). Addresses already advanced past byte.
//  Any byte cycle completing with Length1=1 (no mismatch) -> DONE. DONE: XferEnd=1 one cycle -> IDLE.
//  Length1 evaluated only at a completing byte cycle; Length=1 at start => exactly one byte.
//  Write strobes never asserted in START/DONE/VERR/IDLE or while BA=0.
//  Reset mid-transfer: IDLE at next negedge, all outputs to reset values, no XferEnd/VerifyErr pulse.
// STRUCTURE
//  Package reu_pkg: XferType encodings (XFER_STASH/FETCH/SWAP/VERIFY), state enum.
//  Sub-module reu_xfer_datapath: swap latches, data muxing to C64DOut/RAMDOut, comparator.
//  Top holds FSM, START_WAIT counter, strobe/handshake decode.
// TESTING
//  Stash, Length1 high on 3rd byte, BA=1 -> 3 RAM writes with C64DIn, 3 Next* pulses, XferEnd once, nDMA released.
//  Fetch 2 bytes with BA=0 for 2 cycles mid-transfer -> no strobes/Next* during stall, 2 writes total.
//  Swap 1 byte, C64=0x5A RAM=0xA5 -> 2 cycles; C64DOut=0xA5, RAMDOut=0x5A; one Next* pulse; XferEnd.
//  Verify 4 bytes, mismatch on byte 2 -> 2 Next* pulses, VerifyErr 1 cycle, no XferEnd, IDLE.
//  START_WAIT=3 -> first byte cycle exactly 3 cycles after nDMA falls; Execute while Busy ignored.
//  Reset asserted during FETCH -> next negedge nDMA=1, C64DOE=0, Busy=0, no pulses.

Source files
------------

// File: rtl/reu_pkg.sv
// Shared encodings for the REU DMA engine: transfer types and FSM states.
package reu_pkg;

  // Transfer type as written into the REU command register
  typedef enum logic [1:0] {
    XFER_STASH  = 2'b00,
    XFER_FETCH  = 2'b01,
    XFER_SWAP   = 2'b10,
    XFER_VERIFY = 2'b11
  } xfer_type_e;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StStash,
    StFetch,
    StSwapRd,
    StSwapWr,
    StVerify,
    StVerr,
    StDone
  } state_e;

endpackage

// File: rtl/reu_xfer_datapath.sv
// Byte datapath of the DMA engine: swap holding latches, write-data muxing and the
// verify comparator.
module reu_xfer_datapath (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       latch_i,
  input  logic       swap_wr_i,
  input  logic [7:0] c64_din_i,
  input  logic [7:0] ram_din_i,
  output logic [7:0] c64_dout_o,
  output logic [7:0] ram_dout_o,
  output logic       mismatch_o
);

  logic [7:0] c64_byte_q, c64_byte_d;
  logic [7:0] ram_byte_q, ram_byte_d;

  // Capture both bus bytes during the swap read cycle, hold otherwise
  always_comb begin
    c64_byte_d = c64_byte_q;
    ram_byte_d = ram_byte_q;
    if (latch_i) begin
      c64_byte_d = c64_din_i;
      ram_byte_d = ram_din_i;
    end
  end

  // Swap latches update on the falling PHI2 edge like the rest of the engine
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      c64_byte_q <= '0;
      ram_byte_q <= '0;
    end else begin
      c64_byte_q <= c64_byte_d;
      ram_byte_q <= ram_byte_d;
    end
  end

  // Swap writes replay the latched bytes; stash/fetch pass the opposite bus straight through
  always_comb begin
    c64_dout_o = swap_wr_i ? ram_byte_q : ram_din_i;
    ram_dout_o = swap_wr_i ? c64_byte_q : c64_din_i;
    mismatch_o = (c64_din_i != ram_din_i);
  end

endmodule

// File: rtl/reu_dma_engine.sv
// REU DMA transfer engine: owns the bus while a transfer runs and sequences one byte per
// PHI2 cycle (two for swap). Address/length counters live in the register file; this block
// only tells it when to advance.
module reu_dma_engine
  import reu_pkg::*;
#(
  parameter int unsigned RAM_AW     = 19,
  parameter int unsigned START_WAIT = 1
) (
  input  logic              PHI2,
  input  logic              Reset,
  input  logic              Execute,
  input  logic [1:0]        XferType,
  input  logic [15:0]       CA,
  input  logic [RAM_AW-1:0] REUA,
  input  logic              Length1,
  input  logic              BA,
  input  logic [7:0]        C64DIn,
  input  logic [7:0]        RAMDIn,
  output logic              nDMA,
  output logic [15:0]       C64A,
  output logic              C64RnW,
  output logic              C64DOE,
  output logic [7:0]        C64DOut,
  output logic [RAM_AW-1:0] RAMA,
  output logic              RAMnOE,
  output logic              RAMnWE,
  output logic [7:0]        RAMDOut,
  output logic              NextCA,
  output logic              NextREUA,
  output logic              VerifyErr,
  output logic              XferEnd,
  output logic              Busy
);

  localparam logic [1:0] WaitLast = 2'(START_WAIT - 1);

  state_e     state_q, state_d;
  xfer_type_e xfer_q, xfer_d;
  logic [1:0] wait_q, wait_d;
  logic       swap_latch, swap_wr, mismatch;

  assign C64A = CA;
  assign RAMA = REUA;
  assign nDMA = (state_q == StIdle);
  assign Busy = (state_q != StIdle);

  reu_xfer_datapath u_datapath (
    .clk_i      (PHI2),
    .rst_i      (Reset),
    .latch_i    (swap_latch),
    .swap_wr_i  (swap_wr),
    .c64_din_i  (C64DIn),
    .ram_din_i  (RAMDIn),
    .c64_dout_o (C64DOut),
    .ram_dout_o (RAMDOut),
    .mismatch_o (mismatch)
  );

  // Next-state and bus strobe decode; every strobe is gated by BA so a stall is silent
  always_comb begin
    state_d    = state_q;
    xfer_d     = xfer_q;
    wait_d     = wait_q;
    C64RnW     = 1'b1;
    C64DOE     = 1'b0;
    RAMnOE     = 1'b1;
    RAMnWE     = 1'b1;
    NextCA     = 1'b0;
    NextREUA   = 1'b0;
    VerifyErr  = 1'b0;
    XferEnd    = 1'b0;
    swap_latch = 1'b0;
    swap_wr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Execute) begin
          xfer_d  = xfer_type_e'(XferType);
          wait_d  = '0;
          state_d = StStart;
        end
      end
      // Hold /DMA low so the CPU can finish any pending write cycle
      StStart: begin
        if (wait_q == WaitLast) begin
          unique case (xfer_q)
            XFER_STASH: state_d = StStash;
            XFER_FETCH: state_d = StFetch;
            XFER_SWAP:  state_d = StSwapRd;
            default:    state_d = StVerify;
          endcase
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StStash: begin
        if (BA) begin
          RAMnWE   = 1'b0;
          NextCA   = 1'b1;
          NextREUA = 1'b1;
          if (Length1) state_d = StDone;
        end
      end
      StFetch: begin
        if (BA) begin
          RAMnOE   = 1'b0;
          C64RnW   = 1'b0;
          C64DOE   = 1'b1;
          NextCA   = 1'b1;
          NextREUA = 1'b1;
          if (Length1) state_d = StDone;
        end
      end
      StSwapRd: begin
        if (BA) begin
          RAMnOE     = 1'b0;
          swap_latch = 1'b1;
          state_d    = StSwapWr;
        end
      end
      StSwapWr: begin
        if (BA) begin
          swap_wr  = 1'b1;
          C64RnW   = 1'b0;
          C64DOE   = 1'b1;
          RAMnWE   = 1'b0;
          NextCA   = 1'b1;
          NextREUA = 1'b1;
          state_d  = Length1 ? StDone : StSwapRd;
        end
      end
      // A mismatch aborts even on the last byte; addresses still step past it
      StVerify: begin
        if (BA) begin
          RAMnOE   = 1'b0;
          NextCA   = 1'b1;
          NextREUA = 1'b1;
          if (mismatch) begin
            state_d = StVerr;
          end else if (Length1) begin
            state_d = StDone;
          end
        end
      end
      StVerr: begin
        VerifyErr = 1'b1;
        state_d   = StIdle;
      end
      StDone: begin
        XferEnd = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register, clocked on the falling PHI2 edge
  always_ff @(negedge PHI2) begin
    if (Reset) begin
      state_q <= StIdle;
      xfer_q  <= XFER_STASH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      xfer_q  <= xfer_d;
      wait_q  <= wait_d;
    end
  end

endmodule
